mdu: RTL
========

Name: mdu

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS core. It consumes the two register-file read operands (rs, rt) in the EX stage and holds the architectural HI/LO registers.
- HI/LO values return to the register file write-back path through mfhi/mflo.
- Provides busy/stall signalling so decode holds any later MDU instruction until the current operation completes.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- op_valid  input  1  qualifies op for this cycle.
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- rs_data  input  32  operand A (dividend / multiplicand / mthi-mtlo source).
- rt_data  input  32  operand B (divisor / multiplier).
- busy  output  1  registered; high while an operation is in flight.
- stall_req  output  1  combinational: busy OR (op_valid AND op in 1..4).
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- done  output  1  registered one-cycle pulse when HI/LO are committed by mult/div.

Behaviour:
- Reset (async, any time including mid-operation): hi=0, lo=0, busy=0, done=0, counter=0, and pending results are discarded. The first edge after reset deasserts behaves as idle.
- State machine: IDLE, RUN.
- IDLE → RUN: occurs on a posedge with op_valid=1, op∈{1..4}, busy=0.
  - Capture rs_data and rt_data and the operation.
  - Load counter = MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter reaches 0: write HI/LO, busy←0, done←1 for one cycle, return to IDLE.
  - busy is therefore high for exactly N cycles after the start edge.
- Results:
  - MULT: {hi,lo} = signed 64-bit product of rs×rt.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the dividend's sign.
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
- Division boundaries:
  - Divisor 0 (div or divu): hi/lo are left unchanged, but the full DIV_CYCLES busy period and the done pulse still occur.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- MTHI/MTLO: take effect on the posedge only when busy=0 (hi←rs_data or lo←rs_data) and complete in a single cycle. busy is not asserted and done is not pulsed.
- Any op (1..6) presented while busy=1 is ignored. Upstream must use stall_req to hold the instruction; the unit never queues.
- hi/lo outputs keep their old values throughout RUN and change only at the commit edge (or an mthi/mtlo edge). A mfhi/mflo read during busy is prevented by upstream stall.
- Simultaneous events:
  - The commit edge cannot accept a new start, because busy=1 on that edge.
  - A new start is accepted on the following edge.
  - Back-to-back throughput is therefore N+1 cycles per operation.
- Operand capture occurs at the start edge. Later changes to rs_data/rt_data during RUN have no effect.

Test Plan:
- Reset during RUN:
  - Stimulus: MULT 3×4 started, then reset asserted asynchronously two cycles in (between edges).
  - Response: busy, hi and lo drop to 0 immediately. No done pulse. A subsequent MULTU 0xFFFFFFFF×2 yields hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- Signed vs unsigned multiply:
  - MULT 0xFFFFFFFF×2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
  - In both cases busy is high exactly 5 cycles and done pulses on the commit edge.
- Signed divide:
  - DIV −7 (0xFFFFFFF9) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
  - DIVU 7/2 → lo=3, hi=1.
- Division boundaries:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO. DIV x/0 → busy 10 cycles, done pulses, hi=0x11 and lo=0x22 unchanged.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Ops while busy:
  - Stimulus: during DIV busy, present MTHI 0xABCD and MULT 5×5.
  - Response: both ignored and stall_req=1 throughout. Final hi/lo come from the DIV only. A MULT 5×5 issued on the edge after busy falls gives lo=25, hi=0.
- Single-cycle writes:
  - MTLO 0x1234 while idle → lo=0x1234 on the next edge.
  - busy stays 0, stall_req stays 0, no done pulse.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Operands are captured at the start edge; HI/LO change only at commit or on mthi/mtlo.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             start, commit;
    logic             is_md, is_div_op;

    logic [2:0]       op_p0;
    logic [31:0]      rs_p0, rt_p0;
    logic [63:0]      mul_p0, div_p0;
    logic             is_div_p0;

    // 64-bit product; the low 64 bits are identical for either operand interpretation
    // once the operands are extended according to signedness.
    function automatic logic [63:0] mul_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic sgn);
        logic signed [63:0] pa, pb;
        pa = sgn ? $signed({{32{a[31]}}, a}) : $signed({32'b0, a});
        pb = sgn ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
        return pa * pb;
    endfunction

    // Returns {remainder, quotient}. Works on magnitudes so that 0x80000000 / -1
    // wraps to 0x80000000 instead of overflowing a signed divide.
    function automatic logic [63:0] div_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic sgn);
        logic        neg_a, neg_b;
        logic [31:0] ua, ub, q, r;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        ua    = neg_a ? (~a + 32'd1) : a;
        ub    = neg_b ? (~b + 32'd1) : b;
        q     = ua / ub;
        r     = ua % ub;
        if (neg_a ^ neg_b) q = ~q + 32'd1;
        if (neg_a)         r = ~r + 32'd1;
        return {r, q};
    endfunction

    assign is_md     = (op != OP_NONE) && (op <= OP_DIVU);
    assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    assign busy      = (state == RUN);
    assign stall_req = busy | (op_valid & is_md);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        start   = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid && is_md) begin
                    start   = 1'b1;
                    state_n = RUN;
                    cnt_n   = is_div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            RUN: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

    // ---- stage p0: operands held from the start edge until commit ----
    always_ff @(posedge clk) begin
        if (start) begin
            rs_p0 <= rs_data;
            rt_p0 <= rt_data;
        end
    end

    always_comb begin
        mul_p0    = mul_result(rs_p0, rt_p0, op_p0 == OP_MULT);
        div_p0    = div_result(rs_p0, rt_p0, op_p0 == OP_DIV);
        is_div_p0 = (op_p0 == OP_DIV) || (op_p0 == OP_DIVU);
    end

    // ---- commit: HI/LO update, control state ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            op_p0 <= OP_NONE;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            done  <= commit;
            if (start) op_p0 <= op;
            if (commit) begin
                if (!is_div_p0) begin
                    {hi, lo} <= mul_p0;
                end else if (rt_p0 != 32'd0) begin
                    {hi, lo} <= div_p0;
                end
            end else if (!busy && op_valid) begin
                if (op == OP_MTHI) hi <= rs_data;
                if (op == OP_MTLO) lo <= rs_data;
            end
        end
    end

endmodule
